// File: rtl/sha_256_pkg.sv
// Shared constants and FSM state encoding for the SHA-256 message padder.
package sha_256_pkg;

  localparam int SHA_BLOCK_BITS      = 512;
  localparam int SHA_BLOCK_BYTES     = SHA_BLOCK_BITS / 8;
  localparam int SHA_LEN_FIELD_BYTES = 8;
  localparam int SHA_LEN_FIELD_BITS  = SHA_LEN_FIELD_BYTES * 8;
  localparam logic [7:0] SHA_PAD_BYTE = 8'h80;
  localparam int SHA_LEN_BOUNDARY    = SHA_BLOCK_BYTES - SHA_LEN_FIELD_BYTES - 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_PAD,
    S_EMIT,
    S_EXTRA
  } state_e;

endpackage

// File: rtl/sha_256_padder.sv
// Byte-stream to 512-bit SHA-256 block padder (0x80 marker, zero fill, 64-bit bit length).
// Optional SHA_256_PADDER_LEN_OUT_EN adds msg_len_bits reporting the length field of the final block.
//
// state   | meaning
// S_FILL  | accepting message bytes into the block buffer
// S_PAD   | one cycle: insert 0x80 / zeros / length after the last byte
// S_EMIT  | block presented, held until block_ready
// S_EXTRA | one cycle: build the trailing length-only block
module sha_256_padder
  import sha_256_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
`ifdef SHA_256_PADDER_LEN_OUT_EN
  output logic [63:0]               msg_len_bits,
`endif
  output logic [SHA_BLOCK_BITS-1:0] block_data,
  output logic                      block_valid,
  output logic                      block_last,
  input  logic                      block_ready
);

  state_e                    state_q, state_d;
  logic [SHA_BLOCK_BITS-1:0] data_q, data_d;
  logic [6:0]                byte_idx_q, byte_idx_d;
  logic [LEN_W-1:0]          byte_count_q, byte_count_d;
  logic                      extra_q, extra_d;
  logic                      extra_pad_q, extra_pad_d;
  logic                      last_q, last_d;
  logic [63:0]               len_bits;
  logic                      in_fire;
  logic                      out_fire;

  assign len_bits    = 64'(byte_count_q) << 3;
  assign in_ready    = (state_q == S_FILL) && ena && !rst;
  assign in_fire     = in_valid && in_ready;
  assign block_valid = (state_q == S_EMIT);
  assign out_fire    = block_valid && block_ready && ena;
  assign block_data  = data_q;
  assign block_last  = last_q;

`ifdef SHA_256_PADDER_LEN_OUT_EN
  assign msg_len_bits = (block_valid && last_q) ? len_bits : 64'd0;
`endif

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    byte_idx_d   = byte_idx_q;
    byte_count_d = byte_count_q;
    extra_d      = extra_q;
    extra_pad_d  = extra_pad_q;
    last_d       = last_q;

    case (state_q)
      S_FILL: begin
        if (in_fire) begin
          for (int i = 0; i < SHA_BLOCK_BYTES; i++) begin
            if (byte_idx_q[5:0] == 6'(i)) data_d[SHA_BLOCK_BITS-1-8*i -: 8] = in_data;
          end
          byte_count_d = byte_count_q + LEN_W'(1);
          if (in_last) begin
            byte_idx_d = byte_idx_q + 7'd1;
            state_d    = S_PAD;
          end else if (byte_idx_q == 7'(SHA_BLOCK_BYTES - 1)) begin
            byte_idx_d = '0;
            last_d     = 1'b0;
            extra_d    = 1'b0;
            state_d    = S_EMIT;
          end else begin
            byte_idx_d = byte_idx_q + 7'd1;
          end
        end
      end

      S_PAD: begin
        if (ena) begin
          // A full final block goes out untouched; its marker moves to the extra block.
          if (byte_idx_q == 7'(SHA_BLOCK_BYTES)) begin
            last_d      = 1'b0;
            extra_d     = 1'b1;
            extra_pad_d = 1'b1;
          end else begin
            for (int i = 0; i < SHA_BLOCK_BYTES; i++) begin
              if (7'(i) == byte_idx_q)     data_d[SHA_BLOCK_BITS-1-8*i -: 8] = SHA_PAD_BYTE;
              else if (7'(i) > byte_idx_q) data_d[SHA_BLOCK_BITS-1-8*i -: 8] = 8'h00;
            end
            extra_pad_d = 1'b0;
            if (byte_idx_q <= 7'(SHA_LEN_BOUNDARY)) begin
              data_d[SHA_LEN_FIELD_BITS-1:0] = len_bits;
              last_d  = 1'b1;
              extra_d = 1'b0;
            end else begin
              last_d  = 1'b0;
              extra_d = 1'b1;
            end
          end
          byte_idx_d = '0;
          state_d    = S_EMIT;
        end
      end

      S_EMIT: begin
        if (out_fire) begin
          if (extra_q) begin
            state_d = S_EXTRA;
          end else begin
            state_d    = S_FILL;
            byte_idx_d = '0;
            if (last_q) byte_count_d = '0;
            last_d = 1'b0;
          end
        end
      end

      S_EXTRA: begin
        if (ena) begin
          data_d = '0;
          if (extra_pad_q) data_d[SHA_BLOCK_BITS-1 -: 8] = SHA_PAD_BYTE;
          data_d[SHA_LEN_FIELD_BITS-1:0] = len_bits;
          last_d      = 1'b1;
          extra_d     = 1'b0;
          extra_pad_d = 1'b0;
          state_d     = S_EMIT;
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      data_q       <= '0;
      byte_idx_q   <= '0;
      byte_count_q <= '0;
      extra_q      <= 1'b0;
      extra_pad_q  <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      byte_idx_q   <= byte_idx_d;
      byte_count_q <= byte_count_d;
      extra_q      <= extra_d;
      extra_pad_q  <= extra_pad_d;
      last_q       <= last_d;
    end
  end

endmodule

// File: tb/tb_sha_256_padder.sv
// Scoreboard bench for sha_256_padder: reference padding model feeds an expected-block queue.
module tb_sha_256_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] block_data;
  logic         block_valid;
  logic         block_last;
  logic         block_ready;
`ifdef SHA_256_PADDER_LEN_OUT_EN
  logic [63:0]  msg_len_bits;
`endif

  sha_256_padder #(.LEN_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
`ifdef SHA_256_PADDER_LEN_OUT_EN
    .msg_len_bits(msg_len_bits),
`endif
    .block_data  (block_data),
    .block_valid (block_valid),
    .block_last  (block_last),
    .block_ready (block_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } blk_t;

  blk_t         exp_q[$];
  logic [7:0]   msg_q[$];
  int           rise_q[$];
  logic [511:0] rise_data_q[$];
  int           cyc = 0;
  int           n_total = 0;
  int           n_pass = 0;
  bit           rand_ena = 0, rand_ready = 0;
  bit           ena_force = 1, ready_force = 1;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Standard SHA-256 padding of msg_q, split into 64-byte blocks.
  task automatic push_expected();
    logic [7:0]  p[$];
    logic [63:0] bits;
    blk_t        b;
    int          nb;
    p = msg_q;
    bits = 64'(msg_q.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    for (int bi = 0; bi < nb; bi++) begin
      b.data = '0;
      for (int j = 0; j < 64; j++) b.data[511-8*j -: 8] = p[bi*64+j];
      b.last = (bi == nb - 1);
      exp_q.push_back(b);
    end
  endtask

  initial begin
    cyc = 0;
    forever begin @(posedge clk); cyc++; end
  end

  initial begin
    ena = 1'b1;
    block_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ena         = rand_ena   ? ($urandom_range(0, 7) != 0) : ena_force;
      block_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_force;
    end
  end

  initial begin : monitor
    blk_t e;
    forever begin
      @(negedge clk);
      if (!rst && ena && block_valid && block_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_block: got %0h expected none", block_data);
        end else begin
          e = exp_q.pop_front();
          check("block_data", block_data, e.data);
          check("block_last", 512'(block_last), 512'(e.last));
`ifdef SHA_256_PADDER_LEN_OUT_EN
          check("msg_len_bits", 512'(msg_len_bits), e.last ? 512'(e.data[63:0]) : 512'd0);
`endif
        end
      end
    end
  end

  initial begin : watcher
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (block_valid && !prev_v) begin
        rise_q.push_back(cyc);
        rise_data_q.push_back(block_data);
      end
      prev_v = block_valid;
    end
  end

  task automatic send_msg(input bit with_last, input bit gaps, input int stall_at,
                          output int last_cyc, output int hs64_cyc);
    int t;
    logic         snap_v;
    logic [511:0] snap_d;
    bit           ok;
    last_cyc = -1;
    hs64_cyc = -1;
    for (int i = 0; i < msg_q.size(); i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(posedge clk); #1; end
      if (i == stall_at) begin
        in_valid = 1'b0;
        ena_force = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (ena && t < 20);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = msg_q[i]; in_last = with_last && (i == msg_q.size() - 1);
        snap_v = block_valid; snap_d = block_data; ok = 1;
        repeat (5) begin
          @(negedge clk);
          if (in_ready !== 1'b0 || block_valid !== snap_v || block_data !== snap_d) ok = 0;
          @(posedge clk); #1;
        end
        check("ena_low_hold", 512'(ok), 512'd1);
        ena_force = 1'b1;
      end
      in_valid = 1'b1;
      in_data  = msg_q[i];
      in_last  = with_last && (i == msg_q.size() - 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!in_ready && t < 2000);
      if (!in_ready) begin
        n_total++;
        $display("FAIL in_handshake_timeout: got waited %0d expected accept", t);
        break;
      end
      if (i == 63) hs64_cyc = cyc;
      if (in_last) last_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d blocks pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic new_msg(input int n, input bit zeros);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(zeros ? 8'h00 : 8'($urandom_range(0, 255)));
    rise_q.delete();
    rise_data_q.delete();
  endtask

  initial begin : main
    int lc, h64, t, lat;
    logic [511:0] snap;
    bit ok;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_block_valid", 512'(block_valid), 512'd0);
    check("rst_block_last",  512'(block_last),  512'd0);
    check("rst_block_data",  block_data,        512'd0);
    check("rst_in_ready",    512'(in_ready),    512'd1);
    @(posedge clk); #1;

    // "abc": single block, two-cycle latency from the last byte
    new_msg(0, 0);
    msg_q = '{8'h61, 8'h62, 8'h63};
    push_expected();
    send_msg(1, 0, -1, lc, h64);
    wait_drain();
    lat = (rise_q.size() > 0) ? rise_q[0] - lc : -1;
    check("abc_latency", 512'(lat), 512'd2);
    check("abc_head", (rise_data_q.size() > 0) ? 512'(rise_data_q[0][511:480]) : '1, 512'h61626380);
    check("abc_len",  (rise_data_q.size() > 0) ? 512'(rise_data_q[0][63:0])    : '1, 512'h18);

    new_msg(55, 1);
    push_expected();
    send_msg(1, 0, -1, lc, h64);
    wait_drain();
    check("b55_len", (rise_data_q.size() > 0) ? 512'(rise_data_q[0][63:0]) : '1, 512'h1B8);
    check("b55_pad", (rise_data_q.size() > 0) ? 512'(rise_data_q[0][71:64]) : '1, 512'h80);

    new_msg(56, 0);
    push_expected();
    send_msg(1, 1, -1, lc, h64);
    wait_drain();
    lat = (rise_q.size() > 1) ? rise_q[1] - rise_q[0] : -1;
    check("b56_gap", 512'(lat), 512'd2);
    check("b56_len", (rise_data_q.size() > 1) ? 512'(rise_data_q[1][63:0]) : '1, 512'h1C0);

    new_msg(64, 0);
    push_expected();
    send_msg(1, 0, -1, lc, h64);
    wait_drain();
    check("b64_pad0", (rise_data_q.size() > 1) ? 512'(rise_data_q[1][511:504]) : '1, 512'h80);
    check("b64_len",  (rise_data_q.size() > 1) ? 512'(rise_data_q[1][63:0])    : '1, 512'h200);

    new_msg(100, 0);
    push_expected();
    send_msg(1, 0, -1, lc, h64);
    wait_drain();
    lat = (rise_q.size() > 0) ? rise_q[0] - h64 : -1;
    check("full_block_latency", 512'(lat), 512'd1);

    // consumer backpressure: block held for 10 cycles
    ready_force = 1'b0;
    repeat (2) @(posedge clk); #1;
    new_msg(3, 0);
    push_expected();
    send_msg(1, 0, -1, lc, h64);
    t = 0;
    while (!block_valid && t < 50) begin @(negedge clk); t++; end
    snap = block_data;
    ok = block_valid;
    repeat (10) begin
      @(negedge clk);
      if (block_valid !== 1'b1 || block_data !== snap || in_ready !== 1'b0) ok = 0;
    end
    check("stall_hold", 512'(ok), 512'd1);
    ready_force = 1'b1;
    wait_drain();

    new_msg(20, 0);
    push_expected();
    send_msg(1, 1, 8, lc, h64);
    wait_drain();

    // abort a partial message with reset
    new_msg(30, 0);
    send_msg(0, 0, -1, lc, h64);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid",    512'(block_valid), 512'd0);
    check("abort_in_ready", 512'(in_ready),    512'd1);
    @(posedge clk); #1;
    new_msg(0, 0);
    msg_q = '{8'h61, 8'h62, 8'h63};
    push_expected();
    send_msg(1, 0, -1, lc, h64);
    wait_drain();
    check("abort_abc_len", (rise_data_q.size() > 0) ? 512'(rise_data_q[0][63:0]) : '1, 512'h18);

    rand_ena = 1;
    rand_ready = 1;
    for (int m = 0; m < 25; m++) begin
      new_msg($urandom_range(1, 150), 0);
      push_expected();
      send_msg(1, 1, -1, lc, h64);
    end
    wait_drain();
    rand_ena = 0;
    rand_ready = 0;
    repeat (20) @(posedge clk);
    #1;
    check("leftover_blocks", 512'(exp_q.size()), 512'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
